alarm_ctrl: RTL and testbench
=============================

# alarm_ctrl

Mode and alarm sequencer for the 24-hour alarm clock. Decodes the manual buttons into a registered operating mode (RUN / TIMESET / ALARMSET) and drives the count enables of the time counters (sec, min, hrs) and alarm counters (min, hrs). Runs the alarm state machine (off, armed, ringing, snoozing) from a time==alarm match flag, with snooze and ring auto-timeout. Sits between the button inputs and the counter/display datapath, replacing the ad-hoc enable logic in the top level.

## Interface
- `SNOOZE_SEC`, default 540: snooze length in clock cycles (1 cycle = 1 s); must be ≥ 1.
- `RING_SEC`, default 60: maximum ring duration before auto-stop; must be ≥ 1.
- `clk` in 1: 1 Hz pulse clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `timeset`, `alarmset` in 1 each: mode buttons, level-sensitive.
- `minadv`, `hrsadv` in 1 each: advance buttons, level-sensitive.
- `alarmon` in 1: alarm enable switch.
- `snooze` in 1: snooze button.
- `match` in 1: comparator flag, high while time hrs:min == alarm hrs:min.
- `szero`, `mzero` in 1 each: rollover flags from the seconds and minutes counters.
- `sec_en`, `tmin_en`, `thrs_en`, `amin_en`, `ahrs_en` out 1 each: counter enables.
- `disp_alarm` out 1: display mux select; high shows alarm hrs:min.
- `mode` out 2: current mode, `mode_t` encoding.
- `buzz` out 1: registered buzzer drive.
- `snoozing` out 1: high in SNOOZE state.

## Operation
- Mode FSM (registered `mode`). From RUN: `timeset` → TSET (wins if both buttons are high); else `alarmset` → ASET. From TSET: `!timeset` → RUN. From ASET: `timeset` → TSET; else `!alarmset` → RUN.
- Enables are combinational from registered `mode` and the current inputs:
  - `sec_en` = RUN.
  - `tmin_en` = RUN&`szero` | TSET&`minadv`.
  - `thrs_en` = RUN&`szero`&`mzero` | TSET&`hrsadv`.
  - `amin_en` = ASET&`minadv`.
  - `ahrs_en` = ASET&`hrsadv`.
  - `disp_alarm` = ASET.
- Alarm FSM (`alarm_state_t`: OFF, ARMED, RING, SNOOZE). Trigger = `match` & !`match_q`, where `match_q` is `match` registered.
  - OFF → ARMED when `alarmon`.
  - ARMED → RING on trigger while `mode`==RUN. Timer loads RING_SEC-1.
  - RING → SNOOZE when `snooze`. Timer loads SNOOZE_SEC-1.
  - RING → ARMED when the timer is 0.
  - SNOOZE → RING when the timer is 0. Timer reloads RING_SEC-1.
  - From any state: `!alarmon` → OFF (highest priority). In RING or SNOOZE, `mode`≠RUN → ARMED (second priority).
- Timer: one down-counter, width $clog2(max(SNOOZE_SEC,RING_SEC)), decrements by 1 per cycle in RING/SNOOZE and holds 0 elsewhere. A 0 value with the reload condition takes the transition; the counter never wraps.
- Edge detection means a ring stopped by timeout or a mode change does not re-trigger within the same matching minute. A match that is already high when entering ARMED does not trigger.

## Timing
- Reset values: `mode`=RUN, alarm=OFF, timer=0, `match_q`=1, `buzz`=0, `snoozing`=0.
  - `match_q` resets to 1 so that equal time and alarm registers at reset (both 00:00) do not ring.
- Mode change is visible one cycle after a button edge. Enables follow `mode` in the same cycle (no extra latency), so counters advance on the edge after the mode register updates.
- `buzz` = (next state == RING), registered. It rises one cycle after the `match` rising edge.
- Ring duration is exactly RING_SEC cycles of `buzz` high. Snooze gap is exactly SNOOZE_SEC cycles of `buzz` low.
- `snooze` and timer expiry in the same RING cycle: snooze wins.
- Reset asserted mid-ring: `buzz` falls asynchronously.

## Structure
- `alarm_pkg`: `mode_t` (RUN=0, TSET=1, ASET=2) and `alarm_state_t`. The default SNOOZE_SEC and RING_SEC constants live here too.
- One sub-module, `sec_timer`: a loadable down-counter (`load`, `load_val`, `dec`, `zero`).
- Mode FSM and alarm FSM are separate `always_ff` blocks in `alarm_ctrl`.

## Test plan
- Reset with `match`=1, `alarmon`=1 → `mode`=RUN, `buzz` stays 0 for 100 cycles. `sec_en`=1; `tmin_en` pulses only when `szero`=1.
- `timeset`=1, `minadv`=1 for 5 cycles → `mode`=TSET after 1 cycle, `tmin_en` high for 4 cycles, `sec_en`=0. Both buttons high → TSET.
- `alarmset`=1, `hrsadv`=1 → `disp_alarm`=1, `ahrs_en`=1, `thrs_en`=0. Release → RUN after 1 cycle.
- `alarmon`=1, `match` 0→1 in RUN (RING_SEC=60) → `buzz` high from cycle+1 for exactly 60 cycles. With `match` held high, there is no second ring.
- Ring, `snooze` pulse at ring cycle 10 (SNOOZE_SEC=540) → `buzz` low 540 cycles, `snoozing`=1, then rings again for 60. `alarmon`=0 mid-snooze → OFF next cycle.
- Ringing, `timeset` asserted → alarm returns to ARMED, `buzz`=0 within 2 cycles. A `match` edge during TSET does not ring.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm clock mode and alarm sequencer.
package alarm_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        TSET = 2'd1,
        ASET = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        ARMED  = 2'd1,
        RING   = 2'd2,
        SNOOZE = 2'd3
    } alarm_state_t;

    localparam int SNOOZE_SEC_DEF = 540;
    localparam int RING_SEC_DEF   = 60;

    // Wide enough for max(a,b)-1; never narrower than one bit.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/alarm_ctrl_sec_timer.sv
// Loadable down-counter that saturates at zero; one tick per 1 Hz clock.
module sec_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/alarm_ctrl.sv
// Mode decoder and alarm sequencer: registered operating mode, counter enables,
// and the OFF/ARMED/RING/SNOOZE alarm machine with snooze and ring timeout.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
    parameter int RING_SEC   = RING_SEC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       timeset,
    input  logic       alarmset,
    input  logic       minadv,
    input  logic       hrsadv,
    input  logic       alarmon,
    input  logic       snooze,
    input  logic       match,
    input  logic       szero,
    input  logic       mzero,
    output logic       sec_en,
    output logic       tmin_en,
    output logic       thrs_en,
    output logic       amin_en,
    output logic       ahrs_en,
    output logic       disp_alarm,
    output logic [1:0] mode,
    output logic       buzz,
    output logic       snoozing
);

    localparam int TW = timer_width(SNOOZE_SEC, RING_SEC);
    localparam logic [TW-1:0] RING_LOAD   = TW'(RING_SEC - 1);
    localparam logic [TW-1:0] SNOOZE_LOAD = TW'(SNOOZE_SEC - 1);

    mode_t        r_mode, w_mode_next;
    alarm_state_t r_alarm, w_alarm_next;
    logic         r_match_q, r_buzz;
    logic         w_trigger, w_active, w_zero, w_load;
    logic [TW-1:0] w_load_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= RUN;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        case (r_mode)
            RUN:     if (timeset) w_mode_next = TSET;
                     else if (alarmset) w_mode_next = ASET;
            TSET:    if (!timeset) w_mode_next = RUN;
            ASET:    if (timeset) w_mode_next = TSET;
                     else if (!alarmset) w_mode_next = RUN;
            default: w_mode_next = RUN;
        endcase
    end

    always_comb begin
        sec_en     = (r_mode == RUN);
        tmin_en    = ((r_mode == RUN) && szero) || ((r_mode == TSET) && minadv);
        thrs_en    = ((r_mode == RUN) && szero && mzero) || ((r_mode == TSET) && hrsadv);
        amin_en    = (r_mode == ASET) && minadv;
        ahrs_en    = (r_mode == ASET) && hrsadv;
        disp_alarm = (r_mode == ASET);
    end

    // match_q starts high so identical 00:00 registers after reset do not ring.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_match_q <= 1'b1;
            r_alarm   <= OFF;
            r_buzz    <= 1'b0;
        end else begin
            r_match_q <= match;
            r_alarm   <= w_alarm_next;
            r_buzz    <= (w_alarm_next == RING);
        end
    end

    assign w_trigger = match && !r_match_q;
    assign w_active  = (r_alarm == RING) || (r_alarm == SNOOZE);

    always_comb begin
        w_alarm_next = r_alarm;
        w_load       = 1'b0;
        w_load_val   = '0;
        if (!alarmon) begin
            w_alarm_next = OFF;
        end else if (w_active && (r_mode != RUN)) begin
            w_alarm_next = ARMED;
        end else begin
            case (r_alarm)
                OFF:    w_alarm_next = ARMED;
                ARMED:  if (w_trigger && (r_mode == RUN)) begin
                            w_alarm_next = RING;
                            w_load       = 1'b1;
                            w_load_val   = RING_LOAD;
                        end
                RING:   if (snooze) begin
                            w_alarm_next = SNOOZE;
                            w_load       = 1'b1;
                            w_load_val   = SNOOZE_LOAD;
                        end else if (w_zero) begin
                            w_alarm_next = ARMED;
                        end
                SNOOZE: if (w_zero) begin
                            w_alarm_next = RING;
                            w_load       = 1'b1;
                            w_load_val   = RING_LOAD;
                        end
                default: w_alarm_next = OFF;
            endcase
        end
        // Outside RING/SNOOZE the timer is parked at zero.
        if ((w_alarm_next != RING) && (w_alarm_next != SNOOZE)) begin
            w_load     = 1'b1;
            w_load_val = '0;
        end
    end

    sec_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .dec      (w_active),
        .zero     (w_zero)
    );

    assign mode     = r_mode;
    assign buzz     = r_buzz;
    assign snoozing = (r_alarm == SNOOZE);

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: a ring/snooze countdown model predicts every cycle's outputs.
module tb_alarm_ctrl;

    localparam int RING_N = 60;
    localparam int SNZ_N  = 540;

    logic clk = 1'b0;
    logic rst, timeset, alarmset, minadv, hrsadv, alarmon, snooze, match, szero, mzero;
    logic secEn, tminEn, thrsEn, aminEn, ahrsEn, dispAlarm, buzz, snoozing;
    logic [1:0] mode;

    typedef struct {
        logic [9:0] vec;
        string      tag;
    } exp_t;

    exp_t expQ[$];
    int vectors = 0;
    int miscompares = 0;

    int mMode, mRingLeft, mSnoozeLeft;
    bit mEnabled, mLastMatch;

    always #5 clk = ~clk;

    alarm_ctrl #(.SNOOZE_SEC(SNZ_N), .RING_SEC(RING_N)) dut (
        .clk(clk), .rst(rst), .timeset(timeset), .alarmset(alarmset),
        .minadv(minadv), .hrsadv(hrsadv), .alarmon(alarmon), .snooze(snooze),
        .match(match), .szero(szero), .mzero(mzero),
        .sec_en(secEn), .tmin_en(tminEn), .thrs_en(thrsEn), .amin_en(aminEn),
        .ahrs_en(ahrsEn), .disp_alarm(dispAlarm), .mode(mode), .buzz(buzz),
        .snoozing(snoozing)
    );

    task automatic modelReset();
        mMode = 0; mRingLeft = 0; mSnoozeLeft = 0; mEnabled = 0; mLastMatch = 1;
    endtask

    // Advance the model over one clock edge using the inputs held before that edge.
    task automatic modelClock();
        int oldMode;
        oldMode = mMode;
        if (!alarmon) begin
            mEnabled = 0; mRingLeft = 0; mSnoozeLeft = 0;
        end else if (!mEnabled) begin
            mEnabled = 1;
        end else if ((mRingLeft > 0 || mSnoozeLeft > 0) && oldMode != 0) begin
            mRingLeft = 0; mSnoozeLeft = 0;
        end else if (mRingLeft > 0) begin
            if (snooze) begin
                mRingLeft = 0; mSnoozeLeft = SNZ_N;
            end else begin
                mRingLeft = mRingLeft - 1;
            end
        end else if (mSnoozeLeft > 0) begin
            if (mSnoozeLeft == 1) begin
                mSnoozeLeft = 0; mRingLeft = RING_N;
            end else begin
                mSnoozeLeft = mSnoozeLeft - 1;
            end
        end else if (match && !mLastMatch && oldMode == 0) begin
            mRingLeft = RING_N;
        end
        mLastMatch = match;
        case (oldMode)
            0: if (timeset) mMode = 1; else if (alarmset) mMode = 2;
            1: if (!timeset) mMode = 0;
            default: if (timeset) mMode = 1; else if (!alarmset) mMode = 0;
        endcase
    endtask

    function automatic logic [9:0] modelOutputs();
        logic run, ts, as;
        logic [1:0] m2;
        run = (mMode == 0); ts = (mMode == 1); as = (mMode == 2);
        m2 = mMode[1:0];
        return {m2, run, (run & szero) | (ts & minadv), (run & szero & mzero) | (ts & hrsadv),
                as & minadv, as & hrsadv, as, (mRingLeft > 0), (mSnoozeLeft > 0)};
    endfunction

    task automatic applyStimulus(input bit r, input bit ts, input bit as, input bit ma,
                                 input bit ha, input bit on, input bit sn, input bit m,
                                 input bit sz, input bit mz, input int cycles, input string tag);
        exp_t e;
        repeat (cycles) begin
            @(posedge clk);
            if (rst) modelClock();
            #1;
            rst = r; timeset = ts; alarmset = as; minadv = ma; hrsadv = ha;
            alarmon = on; snooze = sn; match = m; szero = sz; mzero = mz;
            if (!rst) modelReset();
            e.vec = modelOutputs();
            e.tag = tag;
            expQ.push_back(e);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic [9:0] actual;
        actual = {mode, secEn, tminEn, thrsEn, aminEn, ahrsEn, dispAlarm, buzz, snoozing};
        vectors++;
        if (actual !== e.vec) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got {mode,sec,tmin,thrs,amin,ahrs,disp,buzz,snz}=%b expected %b",
                     e.tag, $time, actual, e.vec);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        bit ts, as, on, m;
        int drain;
        rst = 0; timeset = 0; alarmset = 0; minadv = 0; hrsadv = 0;
        alarmon = 1; snooze = 0; match = 1; szero = 0; mzero = 0;
        modelReset();

        applyStimulus(0,0,0,0,0,1,0,1,0,0, 3, "reset");
        for (int i = 0; i < 100; i++)
            applyStimulus(1,0,0,0,0,1,0,1, (i % 7) == 0, (i % 14) == 0, 1, "runHoldNoRing");

        applyStimulus(1,1,0,1,0,1,0,0,1,1, 5, "tsetMinadv");
        applyStimulus(1,0,0,0,0,1,0,0,0,0, 2, "tsetRelease");
        applyStimulus(1,1,1,1,1,1,0,0,0,0, 3, "bothButtons");
        applyStimulus(1,0,0,0,0,1,0,0,0,0, 2, "bothRelease");
        applyStimulus(1,0,1,0,1,1,0,0,1,1, 4, "asetHrsadv");
        applyStimulus(1,0,1,1,0,1,0,0,0,0, 2, "asetMinadv");
        applyStimulus(1,0,0,0,0,1,0,0,0,0, 3, "asetRelease");

        applyStimulus(1,0,0,0,0,1,0,0,0,0, 3, "matchLow");
        applyStimulus(1,0,0,0,0,1,0,1,0,0, 80, "ringHeld");

        applyStimulus(1,0,0,0,0,1,0,0,0,0, 3, "matchLow2");
        applyStimulus(1,0,0,0,0,1,0,1,0,0, 10, "ringPreSnooze");
        applyStimulus(1,0,0,0,0,1,1,1,0,0, 1, "snoozePulse");
        applyStimulus(1,0,0,0,0,1,0,1,0,0, 545, "snoozeGap");
        applyStimulus(1,0,0,0,0,1,0,1,0,0, 65, "ringAgain");
        applyStimulus(1,0,0,0,0,1,0,0,0,0, 2, "matchLow3");
        applyStimulus(1,0,0,0,0,1,0,1,0,0, 5, "ringB");
        applyStimulus(1,0,0,0,0,1,1,1,0,0, 1, "snoozeB");
        applyStimulus(1,0,0,0,0,1,0,1,0,0, 20, "snoozingB");
        applyStimulus(1,0,0,0,0,0,0,1,0,0, 3, "alarmOffMidSnooze");

        applyStimulus(1,0,0,0,0,1,0,0,0,0, 3, "rearm");
        applyStimulus(1,0,0,0,0,1,0,1,0,0, 5, "ringBeforeTset");
        applyStimulus(1,1,0,0,0,1,0,1,0,0, 3, "tsetAbort");
        applyStimulus(1,1,0,0,0,1,0,0,0,0, 1, "tsetMatchLow");
        applyStimulus(1,1,0,0,0,1,0,1,0,0, 3, "matchInTset");
        applyStimulus(1,0,0,0,0,1,0,1,0,0, 5, "afterTset");

        applyStimulus(1,0,0,0,0,1,0,0,0,0, 2, "matchLow4");
        applyStimulus(1,0,0,0,0,1,0,1,0,0, 5, "ringBeforeReset");
        applyStimulus(0,0,0,0,0,1,0,1,0,0, 1, "asyncReset");
        applyStimulus(1,0,0,0,0,1,0,1,0,0, 3, "afterReset");

        ts = 0; as = 0; on = 1; m = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) ts = !ts;
            if ($urandom_range(0, 29) == 0) as = !as;
            if ($urandom_range(0, 199) == 0) on = !on;
            if ($urandom_range(0, 15) == 0) m = !m;
            applyStimulus($urandom_range(0, 599) != 0, ts, as, 1'($urandom), 1'($urandom), on,
                          $urandom_range(0, 29) == 0, m, 1'($urandom), 1'($urandom), 1, "random");
        end

        drain = 0;
        while (expQ.size() > 0 && drain < 5) begin
            @(posedge clk);
            drain++;
        end
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expected vectors left unchecked, required 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
